// File: rtl/m68k_bus_initiator.sv
// 68020-style asynchronous bus initiator with dynamic bus sizing (8/16/32-bit ports).
// Optional WAIT-state abort: define BUS_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog.
module m68k_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        req,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [23:0] A,
    inout  wire  [31:0] D,
    output logic [1:0]  SIZ,
    output logic        AS20,
    output logic        DS20,
    output logic        RW20,
    input  logic [1:0]  DSACK
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_WAIT,
        ST_END,
        ST_DONE
    } state_t;

`ifdef BUS_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           r_state;
    state_t           w_nextState;
    logic [23:0]      r_addr;
    logic [2:0]       r_remaining;
    logic [2:0]       r_moved;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_rw;
    logic             r_err;
    logic [CNT_W-1:0] r_waitCnt;

    logic             w_reqBad;
    logic             w_ack;
    logic             w_timeoutHit;
    logic             w_lastCycle;
    logic [2:0]       w_portBytes;
    logic [2:0]       w_offset;
    logic [2:0]       w_room;
    logic [2:0]       w_moved;
    logic [5:0]       w_movedBits;
    logic [31:0]      w_aligned;
    logic [31:0]      w_readBytes;
    logic [31:0]      w_busWdata;

    assign w_reqBad = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign w_ack        = (DSACK != 2'b11);
    assign w_timeoutHit = TIMEOUT_ON && !w_ack
                       && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_lastCycle  = r_err || (r_remaining == r_moved);

    // Port width and where the current address falls inside that port
    always_comb begin
        w_portBytes = 3'd4;
        w_offset    = {1'b0, r_addr[1:0]};
        case (DSACK)
            2'b01: begin
                w_portBytes = 3'd2;
                w_offset    = {2'b00, r_addr[0]};
            end
            2'b10: begin
                w_portBytes = 3'd1;
                w_offset    = 3'd0;
            end
            default: ;
        endcase
    end

    assign w_room      = w_portBytes - w_offset;
    assign w_moved     = (r_remaining < w_room) ? r_remaining : w_room;
    assign w_movedBits = {w_moved, 3'b000};
    // Shift the first valid lane to the top, then keep only the bytes moved
    assign w_aligned   = D << {w_offset, 3'b000};
    assign w_readBytes = w_aligned >> (6'd32 - w_movedBits);

    always_comb begin
        case (r_remaining)
            3'd1:    w_busWdata = {4{r_wdata[31:24]}};
            3'd2:    w_busWdata = {2{r_wdata[31:16]}};
            default: w_busWdata = r_wdata;
        endcase
    end

    assign D = (!r_rw && (r_state == ST_S1 || r_state == ST_WAIT)) ? w_busWdata : 32'bz;

    assign A         = r_addr;
    assign SIZ       = r_remaining[1:0];
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && r_rw && !r_err) ? r_rdata : 32'h0;

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        AS20        = 1'b1;
        DS20        = 1'b1;
        RW20        = 1'b1;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_nextState = w_reqBad ? ST_DONE : ST_S0;
                end
            end
            ST_S0: begin
                RW20        = r_rw;
                w_nextState = ST_S1;
            end
            ST_S1: begin
                RW20        = r_rw;
                AS20        = 1'b0;
                DS20        = !r_rw;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                RW20 = r_rw;
                AS20 = 1'b0;
                DS20 = 1'b0;
                if (w_ack || w_timeoutHit) begin
                    w_nextState = ST_END;
                end
            end
            ST_END: begin
                RW20        = r_rw;
                w_nextState = w_lastCycle ? ST_DONE : ST_S0;
            end
            ST_DONE: begin
                rsp_valid   = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Operand is held left-justified so the next bytes to send are always on top
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_moved     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rw        <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_rw    <= req_rw;
                        r_addr  <= req_addr;
                        r_err   <= w_reqBad;
                        r_rdata <= '0;
                        r_moved <= '0;
                        case (req_size)
                            2'b00: begin
                                r_remaining <= 3'd1;
                                r_wdata     <= {req_wdata[7:0], 24'h0};
                            end
                            2'b01: begin
                                r_remaining <= 3'd2;
                                r_wdata     <= {req_wdata[15:0], 16'h0};
                            end
                            2'b10: begin
                                r_remaining <= 3'd4;
                                r_wdata     <= req_wdata;
                            end
                            default: begin
                                r_remaining <= 3'd0;
                                r_wdata     <= '0;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_moved <= w_moved;
                        if (r_rw) begin
                            r_rdata <= (r_rdata << w_movedBits) | w_readBytes;
                        end
                    end else if (w_timeoutHit) begin
                        r_err <= 1'b1;
                    end
                end
                ST_END: begin
                    if (!w_lastCycle) begin
                        r_addr      <= r_addr + {21'h0, r_moved};
                        r_remaining <= r_remaining - r_moved;
                        r_wdata     <= r_wdata << {r_moved, 3'b000};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_waitCnt <= '0;
        end else if (r_state == ST_WAIT && !w_ack) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Randomized scoreboard bench for m68k_bus_initiator against a byte-addressed memory
// responder that answers with a chosen port width; timeout case only with BUS_TIMEOUT_EN.
module tb_m68k_bus_initiator;

    logic        CLKCPU = 1'b0;
    logic        RESET  = 1'b0;
    logic        req    = 1'b0;
    logic        req_rw = 1'b1;
    logic [1:0]  req_size  = 2'b00;
    logic [23:0] req_addr  = 24'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  DSACK = 2'b11;
    logic        busy, rsp_valid, rsp_err, AS20, DS20, RW20;
    logic [31:0] rsp_rdata;
    logic [23:0] A;
    logic [1:0]  SIZ;
    tri   [31:0] D;

    logic [31:0] respD = 32'h0;
    logic        respDrive = 1'b0;
    assign D = respDrive ? respD : 32'bz;

    m68k_bus_initiator dut (
        .CLKCPU(CLKCPU), .RESET(RESET),
        .req(req), .req_rw(req_rw), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .A(A), .D(D), .SIZ(SIZ), .AS20(AS20), .DS20(DS20), .RW20(RW20), .DSACK(DSACK)
    );

    always #5 CLKCPU = ~CLKCPU;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        quick;
    } rsp_t;

    typedef struct packed {
        logic [23:0] addr;
        logic [1:0]  siz;
        logic        rw;
    } cyc_t;

    rsp_t        scoreQ[$];
    cyc_t        busQ[$];
    logic [7:0]  modelMem [64];
    logic [7:0]  busMem   [64];
    int          checks = 0;
    int          passes = 0;
    logic [1:0]  portCode = 2'b00;
    bit          stall = 1'b0;
    bit          hung  = 1'b0;
    time         lastAccept = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        $display("[TB] FAIL %s: got event missing/unexpected, want normal protocol", name);
    endtask

    function automatic int portBytesOf(input logic [1:0] code);
        return (code == 2'b00) ? 4 : (code == 2'b01) ? 2 : 1;
    endfunction

    // Expected results come from a flat byte memory and the min(remaining, room) sizing rule
    task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic [23:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] port, input bit timeoutCase);
        rsp_t exp;
        cyc_t c;
        int   nBytes, rem, a, p, n, waited;
        logic bad;
        nBytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        exp.rdata = 32'h0;
        exp.err   = bad || timeoutCase;
        exp.quick = bad;
        if (!bad) begin
            p   = portBytesOf(port);
            rem = nBytes;
            a   = int'(addr);
            if (!timeoutCase) begin
                for (int k = 0; k < nBytes; k++) begin
                    if (rw) exp.rdata = (exp.rdata << 8) | 32'(modelMem[(int'(addr) + k) & 63]);
                    else    modelMem[(int'(addr) + k) & 63] = 8'(wdata >> (8 * (nBytes - 1 - k)));
                end
            end
            while (rem > 0) begin
                n = p - (a % p);
                if (n > rem) n = rem;
                c.addr = a[23:0];
                c.siz  = rem[1:0];
                c.rw   = rw;
                busQ.push_back(c);
                a   += n;
                rem -= n;
                if (timeoutCase) rem = 0;
            end
        end
        scoreQ.push_back(exp);
        portCode = port;
        @(negedge CLKCPU);
        req = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wdata;
        @(posedge CLKCPU);
        lastAccept = $time;
        @(negedge CLKCPU);
        if (!bad) checkOutput("busy_after_accept", 32'(busy), 32'd1);
        waited = 0;
        while (busy && waited < 400) begin
            req       = 1'($urandom_range(0, 1));
            req_rw    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 3));
            req_addr  = 24'($urandom);
            req_wdata = $urandom;
            @(negedge CLKCPU);
            waited++;
        end
        req = 1'b0;
        if (busy) begin
            failNow("completion_bound");
            hung = 1'b1;
        end
        checkOutput("response_seen", 32'(scoreQ.size()), 32'd0);
        scoreQ.delete();
        busQ.delete();
    endtask

    rsp_t e;
    // Response monitor: pops one expectation per completion pulse
    always @(negedge CLKCPU) begin
        if (RESET && rsp_valid) begin
            if (scoreQ.size() == 0) begin
                failNow("unexpected_response");
            end else begin
                e = scoreQ.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                checkOutput("bus_cycles_done", 32'(busQ.size()), 32'd0);
                if (e.quick) checkOutput("err_latency", 32'($time - lastAccept), 32'd5);
            end
        end
    end

    cyc_t c2;
    bit   inCycle = 1'b0;
    bit   acked   = 1'b0;
    int   waitLeft = 0;
    int   rp, rn, rsiz, aInt, base;
    // Memory responder plus per-cycle address/size monitor
    always @(negedge CLKCPU) begin
        if (!RESET || AS20) begin
            inCycle   = 1'b0;
            acked     = 1'b0;
            DSACK     = 2'b11;
            respDrive = 1'b0;
        end else begin
            if (!inCycle) begin
                inCycle  = 1'b1;
                waitLeft = stall ? 1000000 : $urandom_range(0, 4);
                if (busQ.size() == 0) begin
                    failNow("unexpected_bus_cycle");
                end else begin
                    c2 = busQ.pop_front();
                    checkOutput("bus_A", 32'(A), 32'(c2.addr));
                    checkOutput("bus_SIZ", 32'(SIZ), 32'(c2.siz));
                    checkOutput("bus_RW20", 32'(RW20), 32'(c2.rw));
                end
            end
            if (!DS20 && !acked) begin
                if (waitLeft > 0) begin
                    waitLeft--;
                end else begin
                    acked = 1'b1;
                    DSACK = portCode;
                    rp    = portBytesOf(portCode);
                    aInt  = int'(A);
                    rsiz  = (SIZ == 2'b00) ? 4 : int'(SIZ);
                    if (RW20) begin
                        base  = aInt - (aInt % rp);
                        respD = 32'h0;
                        for (int L = 0; L < rp; L++) respD[31 - 8 * L -: 8] = busMem[(base + L) & 63];
                        respDrive = 1'b1;
                    end else begin
                        rn = rp - (aInt % rp);
                        if (rn > rsiz) rn = rsiz;
                        for (int k = 0; k < rn; k++) busMem[(aInt + k) & 63] = D[31 - 8 * ((aInt + k) % rp) -: 8];
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  v;
        logic [1:0]  sz, pc;
        logic [23:0] ad;
        int          sel, off, waited;
        cyc_t        rc;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            modelMem[i] = v;
            busMem[i]   = v;
        end
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h12 + 8'(i) * 8'h22);
            modelMem[i] = v;
            busMem[i]   = v;
        end

        #12;
        checkOutput("reset_AS20", 32'(AS20), 32'd1);
        checkOutput("reset_DS20", 32'(DS20), 32'd1);
        checkOutput("reset_RW20", 32'(RW20), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_A_SIZ", {6'h0, A, SIZ}, 32'h0);
        @(negedge CLKCPU);
        RESET = 1'b1;

        applyStimulus(1'b1, 2'b10, 24'h200000, 32'h0,        2'b00, 1'b0);
        applyStimulus(1'b0, 2'b10, 24'h200004, 32'hAABBCCDD, 2'b10, 1'b0);
        applyStimulus(1'b1, 2'b01, 24'h200002, 32'h0,        2'b01, 1'b0);
        applyStimulus(1'b0, 2'b00, 24'h200003, 32'h0000005A, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b10, 24'h200002, 32'h0,        2'b00, 1'b0);
        applyStimulus(1'b0, 2'b11, 24'h200008, 32'h11223344, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b01, 24'h200001, 32'h0,        2'b00, 1'b0);
        applyStimulus(1'b1, 2'b10, 24'h200004, 32'h0,        2'b01, 1'b0);

        for (int t = 0; t < 60 && !hung; t++) begin
            sel = $urandom_range(0, 9);
            sz  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            off = $urandom_range(0, 59);
            if ($urandom_range(0, 7) != 0) begin
                if (sz == 2'b01) off = off & ~1;
                if (sz == 2'b10) off = off & ~3;
            end
            ad = 24'h200000 + 24'(off);
            pc = 2'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), sz, ad, $urandom, pc, 1'b0);
        end

        if (!hung) begin
            stall    = 1'b1;
            portCode = 2'b00;
            rc.addr = 24'h200010; rc.siz = 2'b00; rc.rw = 1'b1;
            busQ.push_back(rc);
            @(negedge CLKCPU);
            req = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 24'h200010;
            @(negedge CLKCPU);
            req = 1'b0;
            waited = 0;
            while (!(AS20 == 1'b0 && DS20 == 1'b0) && waited < 20) begin
                @(negedge CLKCPU);
                waited++;
            end
            if (waited >= 20) failNow("reach_wait_bound");
            @(negedge CLKCPU);
            #2 RESET = 1'b0;
            #1;
            checkOutput("midreset_AS20", 32'(AS20), 32'd1);
            checkOutput("midreset_DS20", 32'(DS20), 32'd1);
            checkOutput("midreset_busy", 32'(busy), 32'd0);
            checkOutput("midreset_rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
            checkOutput("midreset_A_SIZ", {6'h0, A, SIZ}, 32'h0);
            @(negedge CLKCPU);
            @(negedge CLKCPU);
            RESET = 1'b1;
            stall = 1'b0;
            scoreQ.delete();
            busQ.delete();
        end

`ifdef BUS_TIMEOUT_EN
        if (!hung) begin
            stall = 1'b1;
            applyStimulus(1'b1, 2'b10, 24'h200020, 32'h0, 2'b00, 1'b1);
            stall = 1'b0;
        end
`endif

        for (int i = 0; i < 64; i++) begin
            checkOutput("final_memory", 32'(busMem[i]), 32'(modelMem[i]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
